// File: rtl/tl_ul_arb2_pkg.sv
// tl_ul_arb2_pkg: shared opcodes, beat geometry, FSM state and beat-count helper for tl_ul_arb2
package tl_ul_arb2_pkg;
  localparam logic [2:0] PUT_FULL = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] GET = 3'd4;
  localparam logic [2:0] ACK = 3'd0;
  localparam logic [2:0] ACK_DATA = 3'd1;
  localparam int BEAT_BYTES = 4;
  localparam int BEAT_LG = $clog2(BEAT_BYTES);
  localparam int CNT_W = 4;
  typedef enum logic {IDLE, BURST} state_e;
  // Number of 4-byte beats a transfer of 2**size bytes occupies (1..16 for size 0..6).
  function automatic logic [4:0] beats(input logic [3:0] size);
    return (size <= 4'(BEAT_LG)) ? 5'd1 : 5'd1 << (size - 4'(BEAT_LG));
  endfunction
endpackage

// File: rtl/tl_ul_arb2_cnt.sv
// tl_ul_arb2_cnt: saturating up/down outstanding-request counter for one master
// Ports: clock, reset_n (async active-low); inc/dec pulses; avail = count below MAX_OUT.
module tl_ul_arb2_cnt import tl_ul_arb2_pkg::*; #(
  parameter int MAX_OUT = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic inc,
  input  logic dec,
  output logic avail
);
  localparam logic [CNT_W-1:0] MAX = CNT_W'(MAX_OUT);
  logic [CNT_W-1:0] cnt;
  assign avail = cnt < MAX;
  // Simultaneous inc/dec cancels; decrement of an empty counter (stray D) is ignored.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (inc && !dec && cnt != MAX) cnt <= cnt + 1'b1;
    else if (dec && !inc && cnt != '0) cnt <= cnt - 1'b1;
endmodule

// File: rtl/tl_ul_arb2.sv
// tl_ul_arb2: two-master to one-slave TileLink-UL arbiter with burst lock and outstanding limits
// Ports: clock, reset_n (async active-low); m0_a_*/m1_a_* master A channels; s_a_* slave A
// channel with source = {grant_id, master source}; s_d_* slave D channel routed by
// s_d_source[SRC_W] to m0_d_*/m1_d_*.
// Build option: define TL_ARB2_RR_EN for round-robin arbitration, else master 0 has priority.
module tl_ul_arb2 import tl_ul_arb2_pkg::*; #(
  parameter int SRC_W = 2,
  parameter int MAX_OUT = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             m0_a_valid,
  output logic             m0_a_ready,
  input  logic [2:0]       m0_a_opcode,
  input  logic [3:0]       m0_a_size,
  input  logic [SRC_W-1:0] m0_a_source,
  input  logic [31:0]      m0_a_address,
  input  logic [3:0]       m0_a_mask,
  input  logic [31:0]      m0_a_data,
  input  logic             m1_a_valid,
  output logic             m1_a_ready,
  input  logic [2:0]       m1_a_opcode,
  input  logic [3:0]       m1_a_size,
  input  logic [SRC_W-1:0] m1_a_source,
  input  logic [31:0]      m1_a_address,
  input  logic [3:0]       m1_a_mask,
  input  logic [31:0]      m1_a_data,
  output logic             s_a_valid,
  input  logic             s_a_ready,
  output logic [2:0]       s_a_opcode,
  output logic [3:0]       s_a_size,
  output logic [SRC_W:0]   s_a_source,
  output logic [31:0]      s_a_address,
  output logic [3:0]       s_a_mask,
  output logic [31:0]      s_a_data,
  input  logic             s_d_valid,
  output logic             s_d_ready,
  input  logic [2:0]       s_d_opcode,
  input  logic [3:0]       s_d_size,
  input  logic [SRC_W:0]   s_d_source,
  input  logic [31:0]      s_d_data,
  input  logic             s_d_denied,
  output logic             m0_d_valid,
  input  logic             m0_d_ready,
  output logic [2:0]       m0_d_opcode,
  output logic [3:0]       m0_d_size,
  output logic [SRC_W-1:0] m0_d_source,
  output logic [31:0]      m0_d_data,
  output logic             m0_d_denied,
  output logic             m1_d_valid,
  input  logic             m1_d_ready,
  output logic [2:0]       m1_d_opcode,
  output logic [3:0]       m1_d_size,
  output logic [SRC_W-1:0] m1_d_source,
  output logic [31:0]      m1_d_data,
  output logic             m1_d_denied
);
  state_e state, state_d;
  logic [3:0] a_beats, a_beats_d, d_beats, d_beats_d;
  logic lock_id, lock_d;
  logic av0, av1, e0, e1, arb_id, gnt, gnt_vld;
  logic a_fire, first_fire, multi, d_sel, d_fire, d_last;
  logic [4:0] a_len, d_len;
  assign e0 = m0_a_valid && av0;
  assign e1 = m1_a_valid && av1;
`ifdef TL_ARB2_RR_EN
  logic rr_ptr;
  assign arb_id = (e0 && e1) ? rr_ptr : e1;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) rr_ptr <= 1'b0;
    else if (first_fire) rr_ptr <= ~gnt;
`else
  assign arb_id = !e0 && e1;
`endif
  // Mid-burst the locked master owns the slave regardless of its outstanding count.
  assign gnt = (state == BURST) ? lock_id : arb_id;
  assign gnt_vld = (state == BURST) ? (lock_id ? m1_a_valid : m0_a_valid) : (e0 || e1);
  // Handshake outputs are forced low while reset is held, independent of the flops.
  assign s_a_valid = reset_n && gnt_vld;
  assign m0_a_ready = reset_n && gnt_vld && s_a_ready && !gnt;
  assign m1_a_ready = reset_n && gnt_vld && s_a_ready && gnt;
  assign s_a_opcode = gnt ? m1_a_opcode : m0_a_opcode;
  assign s_a_size = gnt ? m1_a_size : m0_a_size;
  assign s_a_source = {gnt, gnt ? m1_a_source : m0_a_source};
  assign s_a_address = gnt ? m1_a_address : m0_a_address;
  assign s_a_mask = gnt ? m1_a_mask : m0_a_mask;
  assign s_a_data = gnt ? m1_a_data : m0_a_data;
  assign a_fire = s_a_valid && s_a_ready;
  assign first_fire = a_fire && state == IDLE;
  assign a_len = beats(s_a_size) - 5'd1;
  assign multi = (s_a_opcode == PUT_FULL || s_a_opcode == PUT_PARTIAL) && a_len != 5'd0;
  always_comb begin
    state_d = state;
    a_beats_d = a_beats;
    lock_d = lock_id;
    if (first_fire && multi) begin
      state_d = BURST;
      a_beats_d = a_len[3:0];
      lock_d = gnt;
    end else if (a_fire && state == BURST) begin
      a_beats_d = a_beats - 4'd1;
      state_d = (a_beats == 4'd1) ? IDLE : BURST;
    end
  end
  assign d_sel = s_d_source[SRC_W];
  assign m0_d_valid = reset_n && s_d_valid && !d_sel;
  assign m1_d_valid = reset_n && s_d_valid && d_sel;
  assign s_d_ready = reset_n && (d_sel ? m1_d_ready : m0_d_ready);
  assign d_fire = s_d_valid && s_d_ready;
  assign d_len = (s_d_opcode == ACK_DATA) ? beats(s_d_size) - 5'd1 : 5'd0;
  // d_beats == 0 means no response burst is in flight, so this beat is a first beat.
  assign d_last = (d_beats == 4'd0) ? (d_len == 5'd0) : (d_beats == 4'd1);
  assign d_beats_d = !d_fire ? d_beats : (d_beats == 4'd0) ? d_len[3:0] : d_beats - 4'd1;
  assign m0_d_opcode = s_d_opcode;
  assign m0_d_size = s_d_size;
  assign m0_d_source = s_d_source[SRC_W-1:0];
  assign m0_d_data = s_d_data;
  assign m0_d_denied = s_d_denied;
  assign m1_d_opcode = s_d_opcode;
  assign m1_d_size = s_d_size;
  assign m1_d_source = s_d_source[SRC_W-1:0];
  assign m1_d_data = s_d_data;
  assign m1_d_denied = s_d_denied;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      a_beats <= '0;
      lock_id <= 1'b0;
      d_beats <= '0;
    end else begin
      state <= state_d;
      a_beats <= a_beats_d;
      lock_id <= lock_d;
      d_beats <= d_beats_d;
    end
  tl_ul_arb2_cnt #(.MAX_OUT(MAX_OUT)) u_cnt0 (
    .clock(clock), .reset_n(reset_n),
    .inc(first_fire && !gnt), .dec(d_fire && d_last && !d_sel), .avail(av0)
  );
  tl_ul_arb2_cnt #(.MAX_OUT(MAX_OUT)) u_cnt1 (
    .clock(clock), .reset_n(reset_n),
    .inc(first_fire && gnt), .dec(d_fire && d_last && d_sel), .avail(av1)
  );
endmodule

// File: tb/tb_tl_ul_arb2.sv
// tb_tl_ul_arb2: vector table, directed corner sequences and randomized traffic against a reference model
module tb_tl_ul_arb2;
  import tl_ul_arb2_pkg::*;
  localparam int SRC_W = 2;
  localparam int MAX_OUT = 4;
`ifdef TL_ARB2_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;
  logic [1:0] av, dr;
  logic [1:0][2:0] aop;
  logic [1:0][3:0] asz, amsk;
  logic [1:0][SRC_W-1:0] asrc;
  logic [1:0][31:0] aadr, adat;
  logic s_a_ready, s_d_valid, s_d_denied;
  logic [2:0] s_d_opcode;
  logic [3:0] s_d_size;
  logic [SRC_W:0] s_d_source;
  logic [31:0] s_d_data;
  logic m0_a_ready, m1_a_ready, s_a_valid, s_d_ready, m0_d_valid, m1_d_valid, m0_d_denied, m1_d_denied;
  logic [2:0] s_a_opcode, m0_d_opcode, m1_d_opcode;
  logic [3:0] s_a_size, s_a_mask, m0_d_size, m1_d_size;
  logic [SRC_W:0] s_a_source;
  logic [SRC_W-1:0] m0_d_source, m1_d_source;
  logic [31:0] s_a_address, s_a_data, m0_d_data, m1_d_data;
  wire [1:0] ar = {m1_a_ready, m0_a_ready};
  wire [1:0] mdv = {m1_d_valid, m0_d_valid};

  tl_ul_arb2 #(.SRC_W(SRC_W), .MAX_OUT(MAX_OUT)) dut (
    .clock(clock), .reset_n(reset_n),
    .m0_a_valid(av[0]), .m0_a_ready(m0_a_ready), .m0_a_opcode(aop[0]), .m0_a_size(asz[0]),
    .m0_a_source(asrc[0]), .m0_a_address(aadr[0]), .m0_a_mask(amsk[0]), .m0_a_data(adat[0]),
    .m1_a_valid(av[1]), .m1_a_ready(m1_a_ready), .m1_a_opcode(aop[1]), .m1_a_size(asz[1]),
    .m1_a_source(asrc[1]), .m1_a_address(aadr[1]), .m1_a_mask(amsk[1]), .m1_a_data(adat[1]),
    .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode), .s_a_size(s_a_size),
    .s_a_source(s_a_source), .s_a_address(s_a_address), .s_a_mask(s_a_mask), .s_a_data(s_a_data),
    .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_opcode(s_d_opcode), .s_d_size(s_d_size),
    .s_d_source(s_d_source), .s_d_data(s_d_data), .s_d_denied(s_d_denied),
    .m0_d_valid(m0_d_valid), .m0_d_ready(dr[0]), .m0_d_opcode(m0_d_opcode), .m0_d_size(m0_d_size),
    .m0_d_source(m0_d_source), .m0_d_data(m0_d_data), .m0_d_denied(m0_d_denied),
    .m1_d_valid(m1_d_valid), .m1_d_ready(dr[1]), .m1_d_opcode(m1_d_opcode), .m1_d_size(m1_d_size),
    .m1_d_source(m1_d_source), .m1_d_data(m1_d_data), .m1_d_denied(m1_d_denied)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    av = '0; dr = '0; aop = '0; asz = '0; amsk = '0; asrc = '0; aadr = '0; adat = '0;
    s_a_ready = 1'b0; s_d_valid = 1'b0; s_d_denied = 1'b0; s_d_opcode = ACK;
    s_d_size = '0; s_d_source = '0; s_d_data = '0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic req(input int n, input logic v, input logic [2:0] op, input logic [3:0] sz);
    av[n] = v; aop[n] = op; asz[n] = sz;
    asrc[n] = SRC_W'(n + 1); aadr[n] = 32'h1000 * (n + 1); adat[n] = 32'hd0 + n; amsk[n] = 4'hf;
  endtask

  task automatic dsend(input logic v, input logic m, input logic [2:0] op, input logic [3:0] sz);
    s_d_valid = v; s_d_source = {m, SRC_W'(1)}; s_d_opcode = op; s_d_size = sz; s_d_data = 32'h5a;
  endtask

  function automatic int nbeats(input int sz);
    return sz <= 2 ? 1 : 1 << (sz - 2);
  endfunction

  typedef struct {
    string nm;
    logic [1:0] v;
    logic sar, dv, dsel;
    logic [1:0] dr;
    logic x_sav;
    logic [1:0] x_ar;
    logic x_msb;
    logic [1:0] x_mdv;
    logic x_sdr;
  } vec_t;
  vec_t vecs[10];

  typedef struct {
    logic m;
    logic [SRC_W-1:0] src;
    logic [2:0] op;
    logic [3:0] sz;
  } rsp_t;
  rsp_t rq[$];

  initial begin
    int mc[2];
    int a_rem, d_rem, k;
    logic g, gv, lock, ptr, sel, from_q;
    logic [1:0] e, inc, dec;
    vecs[0] = '{"idle",    2'b00, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1};
    vecs[1] = '{"m0_only", 2'b01, 1'b1, 1'b0, 1'b0, 2'b11, 1'b1, 2'b01, 1'b0, 2'b00, 1'b1};
    vecs[2] = '{"m1_only", 2'b10, 1'b1, 1'b0, 1'b0, 2'b11, 1'b1, 2'b10, 1'b1, 2'b00, 1'b1};
    vecs[3] = '{"tie",     2'b11, 1'b1, 1'b0, 1'b0, 2'b11, 1'b1, 2'b01, 1'b0, 2'b00, 1'b1};
    vecs[4] = '{"stall",   2'b11, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 2'b00, 1'b0, 2'b00, 1'b1};
    vecs[5] = '{"d_m0",    2'b00, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 2'b00, 1'b0, 2'b01, 1'b1};
    vecs[6] = '{"d_m1_bp", 2'b00, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 2'b10, 1'b0};
    vecs[7] = '{"d_m1",    2'b00, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 2'b00, 1'b0, 2'b10, 1'b1};
    vecs[8] = '{"d_m0_bp", 2'b00, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 2'b00, 1'b0, 2'b01, 1'b0};
    vecs[9] = '{"a_d_mix", 2'b10, 1'b1, 1'b1, 1'b0, 2'b11, 1'b1, 2'b10, 1'b1, 2'b01, 1'b1};

    do_reset();
    #1;
    chk("rst_state", dut.state, IDLE);
    chk("rst_a_beats", dut.a_beats, 0);
    chk("rst_d_beats", dut.d_beats, 0);
    chk("rst_cnt0", dut.u_cnt0.cnt, 0);
    chk("rst_cnt1", dut.u_cnt1.cnt, 0);
    chk("rst_sav", s_a_valid, 0);

    foreach (vecs[i]) begin
      do_reset();
      req(0, vecs[i].v[0], GET, 2);
      req(1, vecs[i].v[1], GET, 2);
      s_a_ready = vecs[i].sar;
      dsend(vecs[i].dv, vecs[i].dsel, ACK, 0);
      dr = vecs[i].dr;
      #1;
      chk({vecs[i].nm, "_sav"}, s_a_valid, vecs[i].x_sav);
      chk({vecs[i].nm, "_ar"}, ar, vecs[i].x_ar);
      if (vecs[i].x_sav) chk({vecs[i].nm, "_msb"}, s_a_source[SRC_W], vecs[i].x_msb);
      chk({vecs[i].nm, "_mdv"}, mdv, vecs[i].x_mdv);
      chk({vecs[i].nm, "_sdr"}, s_d_ready, vecs[i].x_sdr);
    end

    // Simultaneous Gets: first grant to m0, second follows the arbitration policy.
    do_reset();
    req(0, 1, GET, 2); req(1, 1, GET, 2); s_a_ready = 1;
    #1;
    chk("r35_c0_msb", s_a_source[SRC_W], 0);
    chk("r35_c0_rdy", ar, 2'b01);
    cyc(); #1;
    chk("r35_c1_msb", s_a_source[SRC_W], RR);
    chk("r35_c1_rdy", ar, RR ? 2'b10 : 2'b01);

    // 4-beat PutFull from m0 keeps the grant through a stall; m1 waits for the 5th accept.
    do_reset();
    req(0, 1, PUT_FULL, 4); req(1, 1, GET, 2); s_a_ready = 1;
    for (int b = 0; b < 4; b++) begin
      if (b == 2) begin
        av[0] = 0;
        #1;
        chk("r36_stall_sav", s_a_valid, 0);
        chk("r36_stall_rdy", ar, 2'b00);
        cyc();
        av[0] = 1;
      end
      #1;
      chk("r36_beat_rdy", ar, 2'b01);
      chk("r36_beat_msb", s_a_source[SRC_W], 0);
      cyc();
    end
    av[0] = 0;
    #1;
    chk("r36_m1_rdy", ar, 2'b10);
    chk("r36_m1_msb", s_a_source[SRC_W], 1);

    // Outstanding limit: fifth Get held until one response retires.
    do_reset();
    req(0, 1, GET, 2); s_a_ready = 1; dr = 2'b11;
    for (int n = 0; n < 4; n++) begin
      #1 chk("r37_get_rdy", m0_a_ready, 1);
      cyc();
    end
    #1;
    chk("r37_held_rdy", m0_a_ready, 0);
    chk("r37_held_sav", s_a_valid, 0);
    cyc();
    dsend(1, 0, ACK, 2);
    #1;
    chk("r37_ack_rdy", m0_a_ready, 0);
    chk("r37_ack_dv", m0_d_valid, 1);
    cyc();
    dsend(0, 0, ACK, 2);
    #1 chk("r37_resume_rdy", m0_a_ready, 1);
    cyc();
    av = '0;
    #1 chk("r37_cnt0", dut.u_cnt0.cnt, 4);

    // Two-beat AccessAckData to m1 retires the request only on the second beat.
    do_reset();
    dr = 2'b11; req(1, 1, GET, 3); s_a_ready = 1;
    #1;
    chk("r38_a_rdy", ar, 2'b10);
    chk("r38_a_msb", s_a_source[SRC_W], 1);
    cyc();
    av = '0;
    #1 chk("r38_cnt_a", dut.u_cnt1.cnt, 1);
    dsend(1, 1, ACK_DATA, 3);
    #1 chk("r38_b1_dv", mdv, 2'b10);
    cyc();
    #1;
    chk("r38_cnt_mid", dut.u_cnt1.cnt, 1);
    chk("r38_b2_dv", mdv, 2'b10);
    cyc();
    dsend(0, 1, ACK_DATA, 3);
    #1 chk("r38_cnt_end", dut.u_cnt1.cnt, 0);

    // Reset asserted during beat 2 of a 4-beat Put.
    do_reset();
    req(0, 1, PUT_FULL, 4); s_a_ready = 1; dr = 2'b11;
    #1 chk("r39_b1_rdy", m0_a_ready, 1);
    cyc();
    #1 chk("r39_b2_rdy", m0_a_ready, 1);
    reset_n = 0;
    req(1, 1, GET, 2);
    dsend(1, 0, ACK, 2);
    for (int n = 0; n < 2; n++) begin
      #1;
      chk("r39_rst_ar", ar, 2'b00);
      chk("r39_rst_sav", s_a_valid, 0);
      chk("r39_rst_sdr", s_d_ready, 0);
      chk("r39_rst_mdv", mdv, 2'b00);
      chk("r39_rst_cnt0", dut.u_cnt0.cnt, 0);
      chk("r39_rst_state", dut.state, IDLE);
      cyc();
    end
    reset_n = 1; av[0] = 0; dsend(0, 0, ACK, 2);
    #1 chk("r39_post_m1", ar, 2'b10);

    // First-beat accept and last D beat for m0 in the same cycle.
    do_reset();
    dr = 2'b11; req(0, 1, GET, 2); s_a_ready = 1;
    #1;
    cyc();
    #1 chk("r40_cnt_pre", dut.u_cnt0.cnt, 1);
    dsend(1, 0, ACK, 2);
    #1;
    chk("r40_a_rdy", m0_a_ready, 1);
    chk("r40_d_dv", m0_d_valid, 1);
    cyc();
    dsend(0, 0, ACK, 2); av = '0;
    #1 chk("r40_cnt_post", dut.u_cnt0.cnt, 1);

    // Randomized traffic against the reference model; the bench acts as the slave.
    do_reset();
    mc = '{0, 0}; a_rem = 0; d_rem = 0; lock = 0; ptr = 0; rq.delete();
    for (int cy = 0; cy < 3000; cy++) begin
      for (int n = 0; n < 2; n++) begin
        k = int'($urandom_range(2));
        av[n] = $urandom_range(2) != 0;
        aop[n] = k == 0 ? PUT_FULL : k == 1 ? PUT_PARTIAL : GET;
        asz[n] = 4'($urandom_range(4));
        asrc[n] = SRC_W'($urandom);
        aadr[n] = $urandom; adat[n] = $urandom; amsk[n] = 4'($urandom);
        dr[n] = $urandom_range(3) != 0;
      end
      s_a_ready = $urandom_range(3) != 0;
      s_d_data = $urandom; s_d_denied = 1'($urandom);
      from_q = 0;
      if (rq.size() > 0 && $urandom_range(2) != 0) begin
        s_d_valid = 1; s_d_source = {rq[0].m, rq[0].src};
        s_d_opcode = rq[0].op; s_d_size = rq[0].sz; from_q = 1;
      end else if (rq.size() == 0 && d_rem == 0 && $urandom_range(15) == 0) begin
        s_d_valid = 1; s_d_source = (SRC_W + 1)'($urandom); s_d_opcode = ACK; s_d_size = 0;
      end else begin
        s_d_valid = 0; s_d_source = (SRC_W + 1)'($urandom);
      end
      #1;
      for (int n = 0; n < 2; n++) e[n] = av[n] && mc[n] < MAX_OUT;
      if (a_rem > 0) begin
        g = lock; gv = av[lock];
      end else begin
        g = (e[0] && e[1]) ? (RR ? ptr : 1'b0) : e[1];
        gv = e[0] || e[1];
      end
      sel = s_d_source[SRC_W];
      chk("rnd_sav", s_a_valid, gv);
      chk("rnd_ar", ar, {gv && s_a_ready && g, gv && s_a_ready && !g});
      if (gv) begin
        chk("rnd_src", s_a_source, {g, asrc[g]});
        chk("rnd_apay", {s_a_opcode, s_a_size, s_a_address, s_a_mask}, {aop[g], asz[g], aadr[g], amsk[g]});
        chk("rnd_adat", s_a_data, adat[g]);
      end
      chk("rnd_mdv", mdv, {s_d_valid && sel, s_d_valid && !sel});
      chk("rnd_sdr", s_d_ready, dr[sel]);
      if (s_d_valid)
        chk("rnd_dpay",
            sel ? {m1_d_opcode, m1_d_size, m1_d_source, m1_d_denied, m1_d_data}
                : {m0_d_opcode, m0_d_size, m0_d_source, m0_d_denied, m0_d_data},
            {s_d_opcode, s_d_size, s_d_source[SRC_W-1:0], s_d_denied, s_d_data});
      inc = '0; dec = '0;
      if (s_d_valid && dr[sel]) begin
        if (d_rem == 0) d_rem = (s_d_opcode == ACK_DATA) ? nbeats(s_d_size) : 1;
        d_rem--;
        if (d_rem == 0) begin
          dec[sel] = 1;
          if (from_q) void'(rq.pop_front());
        end
      end
      if (gv && s_a_ready) begin
        if (a_rem == 0) begin
          inc[g] = 1;
          ptr = ~g;
          if ((aop[g] == PUT_FULL || aop[g] == PUT_PARTIAL) && nbeats(asz[g]) > 1) begin
            a_rem = nbeats(asz[g]) - 1;
            lock = g;
          end
          rq.push_back('{g, asrc[g], (aop[g] == GET) ? ACK_DATA : ACK, asz[g]});
        end else a_rem--;
      end
      for (int n = 0; n < 2; n++) begin
        mc[n] = mc[n] + int'(inc[n]) - int'(dec[n]);
        if (mc[n] < 0) mc[n] = 0;
        if (mc[n] > MAX_OUT) mc[n] = MAX_OUT;
      end
      cyc();
      chk("rnd_cnt0", dut.u_cnt0.cnt, mc[0]);
      chk("rnd_cnt1", dut.u_cnt1.cnt, mc[1]);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
